// File: rtl/wb_frame_reader_if.sv
// Wishbone bus bundle between a burst-reading master and a memory slave.
// Clock and reset travel with the bus so both ends share one domain.
interface wb_frame_reader_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        input  clk, rst, dat_sm, ack, err, rty,
        output cyc, stb, we, sel, adr, cti, bte, dat_ms
    );

    modport slave (
        input  clk, rst, cyc, stb, we, sel, adr, cti, bte, dat_ms,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wb_frame_reader.sv
// Wishbone burst-read master that loops over a framebuffer and streams the words
// out through a first-word-fall-through FIFO, flagging word 0 of every frame.
module wb_frame_reader #(
    parameter logic [31:0] BASE_ADR   = 32'h0,
    parameter int          NB_WORDS   = 1024,
    parameter int          BURST_LEN  = 16,
    parameter int          FIFO_DEPTH = 64
) (
    wb_frame_reader_if.master wb_m,
    input  logic              enable,
    output logic [31:0]       pix_data,
    output logic              pix_sof,
    output logic              pix_valid,
    input  logic              pix_ready
);
    localparam int IDX_W  = $clog2(NB_WORDS);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NB_WORDS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  BURST_C     = CNT_W'(BURST_LEN);
    localparam logic [2:0]        CTI_CLASSIC = 3'b000;
    localparam logic [2:0]        CTI_INCR    = 3'b010;
    localparam logic [2:0]        CTI_END     = 3'b111;

    if (NB_WORDS % BURST_LEN != 0) begin : g_bad_frame_len
        $error("wb_frame_reader: NB_WORDS must be a multiple of BURST_LEN");
    end
    if (BURST_LEN < 2 || FIFO_DEPTH < BURST_LEN || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_sizes
        $error("wb_frame_reader: need BURST_LEN >= 2 and power-of-2 FIFO_DEPTH >= BURST_LEN");
    end

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t            r_state, w_state_next;
    logic              r_cyc, w_cyc_next;
    logic              r_stb, w_stb_next;
    logic [31:0]       r_adr, w_adr_next;
    logic [2:0]        r_cti, w_cti_next;
    logic [IDX_W-1:0]  r_word_idx, w_word_idx_next;
    logic [BEAT_W-1:0] r_beat, w_beat_next;
    logic [BEAT_W-1:0] w_beat_inc;
    logic [31:0]       w_start_adr;
    logic [CNT_W-1:0]  w_free;

    logic [32:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push, w_pop;
    logic              w_unused_ok;

    assign w_beat_inc  = r_beat + 1'b1;
    assign w_start_adr = BASE_ADR + (32'(r_word_idx) << 2);
    assign w_free      = DEPTH_C - r_count;
    assign w_push      = (r_state == S_BURST) && wb_m.ack;
    assign w_pop       = pix_valid && pix_ready;
    assign w_unused_ok = &{1'b0, wb_m.err, wb_m.rty};

    always_comb begin
        w_state_next    = r_state;
        w_cyc_next      = r_cyc;
        w_stb_next      = r_stb;
        w_adr_next      = r_adr;
        w_cti_next      = r_cti;
        w_word_idx_next = r_word_idx;
        w_beat_next     = r_beat;
        case (r_state)
            S_IDLE: begin
                // A whole burst of FIFO space is claimed up front, so acks never overflow.
                if (enable && w_free >= BURST_C) begin
                    w_state_next = S_BURST;
                    w_cyc_next   = 1'b1;
                    w_stb_next   = 1'b1;
                    w_adr_next   = w_start_adr;
                    w_cti_next   = CTI_INCR;
                end
            end
            S_BURST: begin
                if (wb_m.ack) begin
                    w_word_idx_next = (r_word_idx == LAST_IDX) ? '0 : r_word_idx + 1'b1;
                    w_adr_next      = r_adr + 32'd4;
                    if (r_beat == LAST_BEAT) begin
                        w_state_next = S_IDLE;
                        w_cyc_next   = 1'b0;
                        w_stb_next   = 1'b0;
                        w_cti_next   = CTI_CLASSIC;
                        w_beat_next  = '0;
                    end else begin
                        w_beat_next = w_beat_inc;
                        w_cti_next  = (w_beat_inc == LAST_BEAT) ? CTI_END : CTI_INCR;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_m.clk) begin
        if (wb_m.rst) begin
            r_state    <= S_IDLE;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_adr      <= BASE_ADR;
            r_cti      <= CTI_CLASSIC;
            r_word_idx <= '0;
            r_beat     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cyc      <= w_cyc_next;
            r_stb      <= w_stb_next;
            r_adr      <= w_adr_next;
            r_cti      <= w_cti_next;
            r_word_idx <= w_word_idx_next;
            r_beat     <= w_beat_next;
        end
    end

    always_ff @(posedge wb_m.clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_word_idx == '0, wb_m.dat_sm};
        end
    end

    always_ff @(posedge wb_m.clk) begin
        if (wb_m.rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge wb_m.clk) disable iff (wb_m.rst)
        !(w_push && r_count == DEPTH_C))
        else $error("wb_frame_reader: FIFO push while full");

    // Fall-through read: the head word is visible the cycle after its ack.
    assign pix_valid          = (r_count != '0);
    assign {pix_sof, pix_data} = r_mem[r_rd_ptr];

    assign wb_m.cyc    = r_cyc;
    assign wb_m.stb    = r_stb;
    assign wb_m.adr    = r_adr;
    assign wb_m.cti    = r_cti;
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = 4'hF;
    assign wb_m.bte    = 2'b00;
    assign wb_m.dat_ms = 32'h0;
endmodule

// File: tb/tb_wb_frame_reader.sv
// Bench for wb_frame_reader: memory slave returning mem[i]=i, a frame-position
// reference model feeding a scoreboard, and a monitor checking bus and pixel sides.
`timescale 1ns/1ps
module tb_wb_frame_reader;
    localparam int          NBW  = 64;
    localparam int          BL   = 16;
    localparam int          FD   = 32;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        enable    = 1'b0;
    logic        pix_ready = 1'b0;
    logic [31:0] pix_data;
    logic        pix_sof;
    logic        pix_valid;

    always #5 clk = ~clk;

    wb_frame_reader_if bus (.clk(clk), .rst(rst));

    wb_frame_reader #(
        .BASE_ADR(BASE), .NB_WORDS(NBW), .BURST_LEN(BL), .FIFO_DEPTH(FD)
    ) dut (
        .wb_m      (bus),
        .enable    (enable),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready)
    );

    // Slave: 0 = ack every cycle, 1 = random gaps, 2 = every other cycle.
    int   ack_mode = 0;
    logic r_gate   = 1'b1;
    always @(posedge clk) begin
        case (ack_mode)
            0:       r_gate <= 1'b1;
            1:       r_gate <= 1'($urandom_range(0, 1));
            default: r_gate <= ~r_gate;
        endcase
    end
    assign bus.ack    = bus.cyc & bus.stb & r_gate & ~bus.we;
    assign bus.dat_sm = bus.ack ? ((bus.adr - BASE) >> 2) : 32'hDEAD_BEEF;
    assign bus.err    = 1'b0;
    assign bus.rty    = 1'b0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          model_idx  = 0;
    int          model_beat = 0;
    int          ack_total  = 0;
    int          bursts     = 0;
    int          pix_count  = 0;
    int          sof_count  = 0;
    logic        prev_cyc   = 1'b0;
    logic [32:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out, got no event, expected one (t=%0t)", name, $time);
    endtask

    task automatic wait_beat(input int b, input string name);
        int k;
        for (k = 0; k < 2000 && !(bus.cyc && model_beat == b); k++) step(1);
        if (k == 2000) timeout(name);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 2000 && bus.cyc; k++) step(1);
        if (k == 2000) timeout(name);
    endtask

    task automatic wait_pix(input int target, input string name);
        int k;
        for (k = 0; k < 4000 && pix_count < target; k++) step(1);
        if (k == 4000) timeout(name);
    endtask

    // Monitor: model advances one frame word per accepted beat; pixels pop the scoreboard.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            exp_q.delete();
            model_idx  = 0;
            model_beat = 0;
            prev_cyc   = 1'b0;
        end else begin
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pix_extra: got data=%0d sof=%0b, expected no word", pix_data, pix_sof);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_data", 64'(pix_data), 64'(e[31:0]));
                    chk("pix_sof", 64'(pix_sof), 64'(e[32]));
                    $display("PIX %0d data=%0d sof=%0b", pix_count, pix_data, pix_sof);
                    pix_count++;
                    if (pix_sof) sof_count++;
                end
            end
            if (bus.cyc) begin
                if (!prev_cyc) bursts++;
                chk("bus_stb", 64'(bus.stb), 64'(1));
                chk("bus_adr", 64'(bus.adr), 64'(BASE + 32'(4 * model_idx)));
                chk("bus_cti", 64'(bus.cti), (model_beat == BL - 1) ? 64'(7) : 64'(2));
                if (bus.ack) begin
                    exp_q.push_back({model_idx == 0, 32'(model_idx)});
                    model_idx  = (model_idx + 1) % NBW;
                    model_beat = (model_beat + 1) % BL;
                    ack_total++;
                end
            end else begin
                chk("idle_stb", 64'(bus.stb), 64'(0));
                chk("idle_cti", 64'(bus.cti), 64'(0));
            end
            prev_cyc = bus.cyc;
        end
    end

    initial begin
        int base;
        int b0;
        step(3);
        chk("rst_cyc", 64'(bus.cyc), 64'(0));
        chk("rst_stb", 64'(bus.stb), 64'(0));
        chk("rst_cti", 64'(bus.cti), 64'(0));
        chk("rst_adr", 64'(bus.adr), 64'(BASE));
        chk("rst_valid", 64'(pix_valid), 64'(0));
        chk("tie_we", 64'(bus.we), 64'(0));
        chk("tie_sel", 64'(bus.sel), 64'(4'hF));

        // Consumer stalled: exactly two bursts fit the FIFO.
        rst = 1'b0; enable = 1'b1; pix_ready = 1'b0;
        step(150);
        chk("stall_bursts", 64'(bursts), 64'(2));
        chk("stall_fill", 64'(exp_q.size()), 64'(32));
        chk("stall_cyc", 64'(bus.cyc), 64'(0));
        chk("stall_valid", 64'(pix_valid), 64'(1));

        // Free-running over more than two frames.
        pix_ready = 1'b1;
        wait_pix(160, "frames_wait");
        chk("sof_count", 64'(sof_count), 64'(3));

        // Random consumer back-pressure and random ack spacing.
        ack_mode = 1;
        for (int i = 0; i < 400; i++) begin
            pix_ready = 1'($urandom_range(0, 1));
            step(1);
        end
        pix_ready = 1'b1;

        // Disable mid-burst: the burst still finishes, nothing new starts.
        wait_beat(5, "beat5_wait");
        enable = 1'b0;
        base   = ack_total;
        wait_idle("tail_wait");
        chk("tail_acks", 64'(ack_total - base), 64'(11));
        b0 = bursts;
        step(100);
        chk("no_new_burst", 64'(bursts), 64'(b0));
        chk("disabled_cyc", 64'(bus.cyc), 64'(0));
        chk("disabled_drain", 64'(pix_valid), 64'(0));

        // Re-enable with a slave acking every other cycle; stream resumes in place.
        enable   = 1'b1;
        ack_mode = 2;
        base     = ack_total;
        for (int k = 0; k < 2000 && ack_total - base < 48; k++) step(1);
        chk("alt_acks", 64'(ack_total - base >= 48), 64'(1));

        // Reset in the middle of a burst; the restart fetches word 0 with sof.
        ack_mode = 0;
        wait_beat(8, "beat8_wait");
        rst = 1'b1;
        step(1);
        chk("midrst_cyc", 64'(bus.cyc), 64'(0));
        chk("midrst_stb", 64'(bus.stb), 64'(0));
        chk("midrst_valid", 64'(pix_valid), 64'(0));
        rst  = 1'b0;
        base = pix_count;
        wait_pix(base + 40, "restart_wait");

        enable = 1'b0;
        wait_idle("final_idle");
        step(60);
        chk("final_empty", 64'(exp_q.size()), 64'(0));
        chk("final_valid", 64'(pix_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
